// File: rtl/system_param_pkg.sv
`default_nettype none
// ============================================================================
// Module   : system_param_pkg
// Brief    : Shared command opcodes, ALU function codes and FSM encoding.
// Revision : 1.0 - initial release
// ============================================================================
package system_param_pkg;

    localparam logic [1:0] CMD_WR  = 2'd0;
    localparam logic [1:0] CMD_RD  = 2'd1;
    localparam logic [1:0] CMD_ALU = 2'd2;
    localparam logic [1:0] CMD_RSV = 2'd3;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_MUL  = 4'd2;
    localparam logic [3:0] ALU_DIV  = 4'd3;
    localparam logic [3:0] ALU_AND  = 4'd4;
    localparam logic [3:0] ALU_OR   = 4'd5;
    localparam logic [3:0] ALU_NAND = 4'd6;
    localparam logic [3:0] ALU_NOR  = 4'd7;
    localparam logic [3:0] ALU_XOR  = 4'd8;
    localparam logic [3:0] ALU_XNOR = 4'd9;
    localparam logic [3:0] ALU_EQ   = 4'd10;
    localparam logic [3:0] ALU_GT   = 4'd11;
    localparam logic [3:0] ALU_LT   = 4'd12;
    localparam logic [3:0] ALU_SHR  = 4'd13;
    localparam logic [3:0] ALU_SHL  = 4'd14;
    localparam logic [3:0] ALU_ILL  = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/system_param_alu.sv
`default_nettype none
// ============================================================================
// Module   : system_param_alu
// Brief    : Combinational WIDTH-bit ALU with error flag (div-by-zero, func 15).
// Revision : 1.0 - initial release
// ============================================================================
module system_param_alu
    import system_param_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [3:0]       func_i,
    output logic [WIDTH-1:0] result_o,
    output logic             err_o
);

    always_comb begin
        result_o = '0;
        err_o    = 1'b0;
        case (func_i)
            ALU_ADD:  result_o = a_i + b_i;
            ALU_SUB:  result_o = a_i - b_i;
            ALU_MUL:  result_o = a_i * b_i;
            ALU_DIV: begin
                if (b_i == '0) begin
                    result_o = '1;
                    err_o    = 1'b1;
                end else begin
                    result_o = a_i / b_i;
                end
            end
            ALU_AND:  result_o = a_i & b_i;
            ALU_OR:   result_o = a_i | b_i;
            ALU_NAND: result_o = ~(a_i & b_i);
            ALU_NOR:  result_o = ~(a_i | b_i);
            ALU_XOR:  result_o = a_i ^ b_i;
            ALU_XNOR: result_o = ~(a_i ^ b_i);
            ALU_EQ:   result_o = {{(WIDTH-1){1'b0}}, (a_i == b_i)};
            ALU_GT:   result_o = {{(WIDTH-1){1'b0}}, (a_i > b_i)};
            ALU_LT:   result_o = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
            ALU_SHR:  result_o = a_i >> 1;
            ALU_SHL:  result_o = a_i << 1;
            default:  err_o    = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/system_param_datapath.sv
`default_nettype none
// ============================================================================
// Module   : system_param_datapath
// Brief    : Command-driven register file + ALU with handshaked TX response.
// Revision : 1.0 - initial release
// ============================================================================
module system_param_datapath
    import system_param_pkg::*;
#(
    parameter int                       WIDTH    = 8,
    parameter int                       RF_DEPTH = 16,
    parameter int                       ADDR_W   = $clog2(RF_DEPTH),
    parameter int                       NUM_CFG  = 2,
    parameter int                       CFG_BASE = 2,
    parameter logic [NUM_CFG*WIDTH-1:0] CFG_RST  = {8'h20, 8'h81}
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_cmd_valid,
    output logic                     o_cmd_ready,
    input  logic [1:0]               i_cmd_op,
    input  logic [ADDR_W-1:0]        i_cmd_addr_a,
    input  logic [ADDR_W-1:0]        i_cmd_addr_b,
    input  logic [WIDTH-1:0]         i_cmd_data,
    input  logic [3:0]               i_cmd_func,
    input  logic                     i_cmd_wb,
    output logic                     o_tx_valid,
    input  logic                     i_tx_ready,
    output logic [WIDTH-1:0]         o_tx_data,
    output logic                     o_tx_err,
    output logic [NUM_CFG*WIDTH-1:0] o_cfg,
    output logic                     o_busy
);

    state_t              state_q;
    logic [1:0]          op_q;
    logic [ADDR_W-1:0]   addr_a_q;
    logic [ADDR_W-1:0]   addr_b_q;
    logic [WIDTH-1:0]    data_q;
    logic [3:0]          func_q;
    logic                wb_q;
    logic                cmd_ready_q;
    logic                tx_valid_q;
    logic [WIDTH-1:0]    tx_data_q;
    logic                tx_err_q;
    logic [WIDTH-1:0]    rf_q [RF_DEPTH];

    logic [WIDTH-1:0]    alu_res;
    logic                alu_err;
    logic                rf_we_d;
    logic [WIDTH-1:0]    rf_wdata_d;

    system_param_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a_i      (rf_q[addr_a_q]),
        .b_i      (rf_q[addr_b_q]),
        .func_i   (func_q),
        .result_o (alu_res),
        .err_o    (alu_err)
    );

    // Writes happen only on the EXEC edge, always to the latched addr_a.
    always_comb begin
        rf_we_d    = 1'b0;
        rf_wdata_d = data_q;
        if (state_q == ST_EXEC) begin
            if (op_q == CMD_WR) begin
                rf_we_d = 1'b1;
            end else if (op_q == CMD_ALU && wb_q && !alu_err) begin
                rf_we_d    = 1'b1;
                rf_wdata_d = alu_res;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int k = 0; k < RF_DEPTH; k++) begin
                rf_q[k] <= '0;
            end
            for (int k = 0; k < NUM_CFG; k++) begin
                rf_q[CFG_BASE+k] <= CFG_RST[k*WIDTH +: WIDTH];
            end
        end else if (rf_we_d) begin
            rf_q[addr_a_q] <= rf_wdata_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q     <= ST_IDLE;
            op_q        <= CMD_WR;
            addr_a_q    <= '0;
            addr_b_q    <= '0;
            data_q      <= '0;
            func_q      <= '0;
            wb_q        <= 1'b0;
            cmd_ready_q <= 1'b0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= '0;
            tx_err_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (i_cmd_valid && cmd_ready_q) begin
                        op_q        <= i_cmd_op;
                        addr_a_q    <= i_cmd_addr_a;
                        addr_b_q    <= i_cmd_addr_b;
                        data_q      <= i_cmd_data;
                        func_q      <= i_cmd_func;
                        wb_q        <= i_cmd_wb;
                        cmd_ready_q <= 1'b0;
                        state_q     <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    case (op_q)
                        CMD_WR: begin
                            cmd_ready_q <= 1'b1;
                            state_q     <= ST_IDLE;
                        end
                        CMD_RD: begin
                            tx_data_q  <= rf_q[addr_a_q];
                            tx_err_q   <= 1'b0;
                            tx_valid_q <= 1'b1;
                            state_q    <= ST_OUT;
                        end
                        CMD_ALU: begin
                            tx_data_q  <= alu_res;
                            tx_err_q   <= alu_err;
                            tx_valid_q <= 1'b1;
                            state_q    <= ST_OUT;
                        end
                        default: begin
                            tx_data_q  <= '0;
                            tx_err_q   <= 1'b1;
                            tx_valid_q <= 1'b1;
                            state_q    <= ST_OUT;
                        end
                    endcase
                end
                ST_OUT: begin
                    if (i_tx_ready) begin
                        tx_valid_q  <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < NUM_CFG; gi++) begin : g_cfg_out
        assign o_cfg[gi*WIDTH +: WIDTH] = rf_q[CFG_BASE+gi];
    end

    assign o_cmd_ready = cmd_ready_q;
    assign o_tx_valid  = tx_valid_q;
    assign o_tx_data   = tx_data_q;
    assign o_tx_err    = tx_err_q;
    assign o_busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_system_param_datapath.sv
`default_nettype none
// ============================================================================
// Module   : tb_system_param_datapath
// Brief    : Directed + random self-checking bench against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_system_param_datapath;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = '0;
    logic [3:0]  cmd_addr_a = '0;
    logic [3:0]  cmd_addr_b = '0;
    logic [7:0]  cmd_data = '0;
    logic [3:0]  cmd_func = '0;
    logic        cmd_wb = 1'b0;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_err;
    logic [15:0] cfg;
    logic        busy;

    int errors = 0;
    int checks = 0;
    logic [7:0] rf_m [16];

    always #5 clk = ~clk;

    system_param_datapath dut (
        .i_clk        (clk),
        .i_rst        (rst_n),
        .i_cmd_valid  (cmd_valid),
        .o_cmd_ready  (cmd_ready),
        .i_cmd_op     (cmd_op),
        .i_cmd_addr_a (cmd_addr_a),
        .i_cmd_addr_b (cmd_addr_b),
        .i_cmd_data   (cmd_data),
        .i_cmd_func   (cmd_func),
        .i_cmd_wb     (cmd_wb),
        .o_tx_valid   (tx_valid),
        .i_tx_ready   (tx_ready),
        .o_tx_data    (tx_data),
        .o_tx_err     (tx_err),
        .o_cfg        (cfg),
        .o_busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        for (int k = 0; k < 16; k++) rf_m[k] = 8'h00;
        rf_m[2] = 8'h81;
        rf_m[3] = 8'h20;
    endtask

    // Reference ALU from the arithmetic rules; returns {err, result}.
    function automatic logic [8:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
        int ia = int'(a);
        int ib = int'(b);
        int r = 0;
        logic e = 1'b0;
        case (f)
            4'd0:  r = (ia + ib) % 256;
            4'd1:  r = (ia - ib + 256) % 256;
            4'd2:  r = (ia * ib) % 256;
            4'd3:  if (ib == 0) begin r = 255; e = 1'b1; end else r = ia / ib;
            4'd4:  r = int'(a & b);
            4'd5:  r = int'(a | b);
            4'd6:  r = 255 - int'(a & b);
            4'd7:  r = 255 - int'(a | b);
            4'd8:  r = int'(a ^ b);
            4'd9:  r = 255 - int'(a ^ b);
            4'd10: r = (ia == ib) ? 1 : 0;
            4'd11: r = (ia > ib) ? 1 : 0;
            4'd12: r = (ia < ib) ? 1 : 0;
            4'd13: r = ia / 2;
            4'd14: r = (ia * 2) % 256;
            default: begin r = 0; e = 1'b1; end
        endcase
        return {e, 8'(r)};
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
    endtask

    task automatic accept(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                          input logic [7:0] d, input logic [3:0] f, input logic wb);
        wait_ready();
        cmd_valid  = 1'b1;
        cmd_op     = op;
        cmd_addr_a = a;
        cmd_addr_b = b;
        cmd_data   = d;
        cmd_func   = f;
        cmd_wb     = wb;
        @(posedge clk);
        #1;
        cmd_valid  = 1'b0;
        cmd_op     = 2'($urandom);
        cmd_addr_a = 4'($urandom);
        cmd_addr_b = 4'($urandom);
        cmd_data   = 8'($urandom);
        cmd_func   = 4'($urandom);
        cmd_wb     = 1'($urandom);
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                           input logic [7:0] d, input logic [3:0] f, input logic wb, input int stall);
        logic [7:0] exp_d;
        logic       exp_e;
        logic [8:0] r;
        exp_d = 8'h00;
        exp_e = 1'b0;
        r     = alu_ref(rf_m[a], rf_m[b], f);
        case (op)
            2'd1: exp_d = rf_m[a];
            2'd2: begin exp_d = r[7:0]; exp_e = r[8]; end
            2'd3: exp_e = 1'b1;
            default: ;
        endcase
        accept(op, a, b, d, f, wb);
        @(negedge clk);
        chk("exec_busy", {31'd0, busy}, 32'd1);
        chk("exec_ready", {31'd0, cmd_ready}, 32'd0);
        chk("exec_valid", {31'd0, tx_valid}, 32'd0);
        if (op == 2'd0) rf_m[a] = d;
        if (op == 2'd2 && wb && !exp_e) rf_m[a] = exp_d;
        @(negedge clk);
        if (op == 2'd0) begin
            chk("wr_idle_valid", {31'd0, tx_valid}, 32'd0);
            chk("wr_idle_busy", {31'd0, busy}, 32'd0);
        end else begin
            chk("resp_valid", {31'd0, tx_valid}, 32'd1);
            chk("resp_data", {24'd0, tx_data}, {24'd0, exp_d});
            chk("resp_err", {31'd0, tx_err}, {31'd0, exp_e});
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                chk("hold_valid", {31'd0, tx_valid}, 32'd1);
                chk("hold_data", {24'd0, tx_data}, {24'd0, exp_d});
                chk("hold_err", {31'd0, tx_err}, {31'd0, exp_e});
                chk("hold_ready", {31'd0, cmd_ready}, 32'd0);
            end
            tx_ready = 1'b1;
            @(posedge clk);
            #1;
            tx_ready = 1'($urandom);
            chk("post_tx_valid", {31'd0, tx_valid}, 32'd0);
            chk("post_tx_busy", {31'd0, busy}, 32'd0);
            tx_ready = 1'b0;
        end
        chk("cfg", {16'd0, cfg}, {16'd0, rf_m[3], rf_m[2]});
    endtask

    initial begin
        reset_model();
        repeat (3) @(negedge clk);
        chk("rst_cfg", {16'd0, cfg}, 32'h2081);
        chk("rst_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_data", {24'd0, tx_data}, 32'd0);
        chk("rst_err", {31'd0, tx_err}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready_after", {31'd0, cmd_ready}, 32'd1);

        run_cmd(2'd1, 4'd2, 4'd0, 8'h00, 4'd0, 1'b0, 0);

        run_cmd(2'd0, 4'd5, 4'd0, 8'hF0, 4'd0, 1'b0, 0);
        run_cmd(2'd0, 4'd6, 4'd0, 8'h20, 4'd0, 1'b0, 0);
        run_cmd(2'd2, 4'd5, 4'd6, 8'h00, 4'd0, 1'b1, 0);
        run_cmd(2'd1, 4'd5, 4'd0, 8'h00, 4'd0, 1'b0, 0);
        chk("add_wrap_rf5", {24'd0, rf_m[5]}, 32'h10);

        run_cmd(2'd0, 4'd7, 4'd0, 8'h09, 4'd0, 1'b0, 0);
        run_cmd(2'd0, 4'd8, 4'd0, 8'h00, 4'd0, 1'b0, 0);
        run_cmd(2'd2, 4'd7, 4'd8, 8'h00, 4'd3, 1'b1, 0);
        run_cmd(2'd1, 4'd7, 4'd0, 8'h00, 4'd0, 1'b0, 0);

        run_cmd(2'd0, 4'd9, 4'd0, 8'h12, 4'd0, 1'b0, 0);
        run_cmd(2'd0, 4'd10, 4'd0, 8'h10, 4'd0, 1'b0, 0);
        run_cmd(2'd2, 4'd9, 4'd10, 8'h00, 4'd2, 1'b0, 5);

        run_cmd(2'd0, 4'd3, 4'd0, 8'h55, 4'd0, 1'b0, 0);
        run_cmd(2'd2, 4'd4, 4'd5, 8'h00, 4'd15, 1'b1, 0);
        run_cmd(2'd3, 4'd4, 4'd5, 8'h00, 4'd0, 1'b1, 0);
        run_cmd(2'd2, 4'd5, 4'd5, 8'h00, 4'd0, 1'b1, 0);

        for (int i = 0; i < 80; i++) begin
            run_cmd(2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom), 8'($urandom),
                    4'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        run_cmd(2'd0, 4'd5, 4'd0, 8'hAA, 4'd0, 1'b0, 0);
        accept(2'd1, 4'd5, 4'd0, 8'h00, 4'd0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("pre_abort_valid", {31'd0, tx_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_valid", {31'd0, tx_valid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_cfg", {16'd0, cfg}, 32'h2081);
        reset_model();
        @(negedge clk);
        rst_n = 1'b1;
        run_cmd(2'd1, 4'd5, 4'd0, 8'h00, 4'd0, 1'b0, 0);
        run_cmd(2'd1, 4'd3, 4'd0, 8'h00, 4'd0, 1'b0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/system_param_datapath.md
Name: system_param_datapath

Overview:
- Parametrised successor of the system datapath: one command-driven register file, ALU and TX output buffer.
- Width, register-file depth and the number of config registers are parameters.
- Operand and write-back addresses are selectable per command; the fixed R0/R1 operands are gone.
- Adds a valid/ready handshake on both the command and TX sides, plus an error flag. Sits between the UART RX command decoder and the UART TX path.

Parameters:
- WIDTH, 8, data and register width.
- RF_DEPTH, 16, register-file entries; must be a power of 2 and at least 4.
- ADDR_W, $clog2(RF_DEPTH), address width.
- NUM_CFG, 2, config registers exported; mapped at RF[CFG_BASE .. CFG_BASE+NUM_CFG-1].
- CFG_BASE, 2, first config address; CFG_BASE+NUM_CFG must be at most RF_DEPTH.
- CFG_RST, {8'h20,8'h81}, NUM_CFG*WIDTH reset values for the config entries; entry 0 is in the LSBs.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-low reset
- i_cmd_valid  in  1  command valid
- o_cmd_ready  out  1  command ready
- i_cmd_op  in  2  0=WR, 1=RD, 2=ALU, 3=reserved
- i_cmd_addr_a  in  ADDR_W  WR/RD address; ALU operand A and write-back destination
- i_cmd_addr_b  in  ADDR_W  ALU operand B address
- i_cmd_data  in  WIDTH  WR data
- i_cmd_func  in  4  ALU function
- i_cmd_wb  in  1  ALU: write the result back to RF[addr_a]
- o_tx_valid  out  1  TX data valid
- i_tx_ready  in  1  TX accepted
- o_tx_data  out  WIDTH  response data
- o_tx_err  out  1  error qualifier for o_tx_data
- o_cfg  out  NUM_CFG*WIDTH  config register contents, live
- o_busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
Reset:
- FSM goes to IDLE. RF entries are 0, except config entries, which take CFG_RST.
- o_tx_valid, o_tx_data and o_tx_err are 0. o_cmd_ready is 1 one cycle after reset release.

Reset mid-operation:
- Aborts immediately. A pending response is dropped and a pending write is not performed.

FSM states: IDLE, EXEC, OUT.

IDLE:
- o_cmd_ready=1. On a valid&ready edge, latch op, addresses, data, func and wb, then go to EXEC.
- op=3 is accepted, then treated in EXEC as an error response: data 0, err 1.

EXEC (exactly 1 cycle, o_cmd_ready=0):
- WR: RF[addr_a] <= data; go to IDLE. No response.
- RD: o_tx_data <= RF[addr_a], o_tx_err <= 0, o_tx_valid <= 1; go to OUT.
- ALU:
  - A=RF[addr_a], B=RF[addr_b], read from pre-edge contents.
  - Result is registered into o_tx_data with o_tx_err; o_tx_valid <= 1; go to OUT.
  - If wb=1 and err=0, RF[addr_a] <= result on the same edge. If err=1, no write-back.

OUT:
- Hold o_tx_data and o_tx_err stable while o_tx_valid=1 and i_tx_ready=0.
- On the edge where i_tx_ready=1: o_tx_valid <= 0; go to IDLE.

Latency:
- Response valid 1 cycle after accept.
- Minimum command spacing: 2 cycles for WR; 3 cycles for RD and ALU (includes 1 TX handshake cycle).

ALU functions (WIDTH-bit result, combinational):
- 0 ADD, 1 SUB (modulo 2^WIDTH, wrap silently).
- 2 MUL (low WIDTH bits).
- 3 DIV (unsigned). B=0 gives result all-ones and err=1.
- 4 AND, 5 OR, 6 NAND, 7 NOR, 8 XOR, 9 XNOR.
- 10 EQ, 11 GT, 12 LT (unsigned, result 1 or 0).
- 13 SHR A>>1, 14 SHL A<<1.
- 15 is illegal: result 0, err=1.

Config and address rules:
- o_cfg slice i always equals RF[CFG_BASE+i]. It updates the cycle after a WR or write-back to that address.
- Addresses are full range; no out-of-range case exists because RF_DEPTH is a power of 2.
- addr_a == addr_b is legal (for example, A+A).
- Write-back and RD both use the latched address, so no simultaneous command/write hazard exists: a command is only accepted in IDLE.
- i_cmd_* are ignored when not accepted; i_tx_ready is ignored outside OUT.

Decomposition:
- Shared package/defines: op codes (CMD_WR, CMD_RD, CMD_ALU), ALU function codes 0–15, FSM state encoding.
- Sub-module system_param_alu: combinational; inputs A, B, func; outputs result and err; parametrised by WIDTH.
- RF, FSM and output buffer stay in the top module.

Test Plan (WIDTH=8, RF_DEPTH=16, defaults otherwise):
- Reset: check o_cfg=16'h2081, o_tx_valid=0, o_busy=0. Then RD addr 2 -> o_tx_data=8'h81 one cycle after accept, err=0.
- Add with write-back: WR 5=8'hF0, WR 6=8'h20, ALU ADD a=5 b=6 wb=1 -> o_tx_data=8'h10 (wrap), err=0; a following RD 5 -> 8'h10.
- Divide by zero: WR 7=8'h09, WR 8=0, ALU DIV a=7 b=8 wb=1 -> o_tx_data=8'hFF, err=1; RD 7 -> still 8'h09.
- TX backpressure: ALU MUL with 8'h12×8'h10 and i_tx_ready low for 5 cycles -> o_tx_data=8'h20 held, o_tx_valid=1 and o_cmd_ready=0 throughout; after the ready edge, IDLE.
- Config write: WR 3=8'h55 -> o_cfg[15:8]=8'h55 on the next cycle. Then func=15 -> data 0, err=1. Then op=3 -> data 0, err=1.
- Mid-operation reset: assert i_rst low while in OUT -> o_tx_valid=0 immediately, RF and o_cfg return to reset values, next command is accepted normally.
